// File: rtl/ebus_pkg.sv
// ebus_pkg: shared EBUS arbiter types, widths and helpers
package ebus_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, DEMAND, RELEASE} ebus_arb_state_t;

    localparam int EBUS_W = 36;

    function automatic logic [31:0] onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/ebus_rr_pick.sv
// ebus_rr_pick: combinational round-robin priority encoder, search starts at ptr
import ebus_pkg::*;

module ebus_rr_pick #(
    parameter int NREQ = 8,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    logic [IW:0] j;

    assign valid = |req;

    // walk from farthest to nearest so the requester closest to ptr is the last one written
    always_comb begin
        idx = '0;
        j = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = {1'b0, ptr} + (IW+1)'(i);
            j = (j >= (IW+1)'(NREQ)) ? j - (IW+1)'(NREQ) : j;
            if (req[j[IW-1:0]]) idx = j[IW-1:0];
        end
    end

endmodule

// File: rtl/ebus_arbiter.sv
// ebus_arbiter: one-owner EBUS grant with setup/demand/ack/release sequencing; optional timeout via EBUS_ARB_TIMEOUT_EN
import ebus_pkg::*;

module ebus_arbiter #(
    parameter int NREQ      = 8,
    parameter int DATA_W    = EBUS_W,
    parameter int SETUP_CYC = 2,
    parameter int TMO_CYC   = 255
) (
    input  logic                   clk,
    input  logic                   crobar,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic                   xfer_ack,
    output logic [NREQ-1:0]        grant,
    output logic [DATA_W-1:0]      ebus_data,
    output logic                   ebus_demand,
    output logic                   done,
    output logic                   timeout_err,
    output logic                   busy
);

    localparam int IW  = $clog2(NREQ);
    localparam int SCW = $clog2(SETUP_CYC + 1);

    if (NREQ < 2 || SETUP_CYC < 1 || TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_param
        $error("ebus_arbiter: parameter out of range");
    end

    ebus_arb_state_t state;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic [SCW-1:0]  scnt;
    logic            expire;

    ebus_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef EBUS_ARB_TIMEOUT_EN
    logic [7:0] tcnt;

    assign expire = (state == DEMAND) && (tcnt == 8'(TMO_CYC - 1));

    // demand-cycle counter; an ack on the expiry cycle suppresses the error
    always_ff @(posedge clk) begin
        if (crobar) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            tcnt        <= (state == DEMAND && !expire && !xfer_ack) ? tcnt + 1'b1 : '0;
            timeout_err <= expire && !xfer_ack;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // transfer sequencer with registered grant, demand and data mux
    always_ff @(posedge clk) begin
        if (crobar) begin
            state       <= IDLE;
            grant       <= '0;
            ebus_data   <= '0;
            ebus_demand <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            winner      <= '0;
            ptr         <= '0;
            scnt        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= GRANT;
                        winner    <= pick_idx;
                        grant     <= NREQ'(onehot(32'(pick_idx)));
                        ebus_data <= req_data[pick_idx*DATA_W +: DATA_W];
                        busy      <= 1'b1;
                        scnt      <= '0;
                    end
                end
                GRANT: begin
                    ebus_data <= req_data[winner*DATA_W +: DATA_W];
                    scnt      <= scnt + 1'b1;
                    if (scnt == SCW'(SETUP_CYC - 1)) begin
                        state       <= DEMAND;
                        ebus_demand <= 1'b1;
                    end
                end
                DEMAND: begin
                    ebus_data <= req_data[winner*DATA_W +: DATA_W];
                    if (xfer_ack || expire) begin
                        state       <= RELEASE;
                        grant       <= '0;
                        ebus_demand <= 1'b0;
                        ebus_data   <= '0;
                        done        <= 1'b1;
                        ptr         <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ebus_arbiter.sv
// tb_ebus_arbiter: directed + randomized checks of ebus_arbiter against a round-robin transaction model
module tb_ebus_arbiter;

    localparam int N = 8;
    localparam int W = 36;
    localparam int S = 2;
    localparam int T = 4;

    logic           clk = 1'b0;
    logic           crobar;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic           xfer_ack;
    logic [N-1:0]   grant;
    logic [W-1:0]   ebus_data;
    logic           ebus_demand;
    logic           done;
    logic           timeout_err;
    logic           busy;

    int vec = 0;
    int bad = 0;
    int rr  = 0;
    logic [W-1:0] d [N];

    ebus_arbiter #(.NREQ(N), .DATA_W(W), .SETUP_CYC(S), .TMO_CYC(T)) dut (
        .clk         (clk),
        .crobar      (crobar),
        .req         (req),
        .req_data    (req_data),
        .xfer_ack    (xfer_ack),
        .grant       (grant),
        .ebus_data   (ebus_data),
        .ebus_demand (ebus_demand),
        .done        (done),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        vec++;
        assert ($onehot0(grant)) else begin
            bad++;
            $error("FAIL onehot0: observed grant %0h expected at most one bit", grant);
        end
    endtask

    task automatic drive_data(input bit rnd);
        for (int i = 0; i < N; i++) begin
            if (rnd) d[i] = W'({$urandom, $urandom});
            req_data[i*W +: W] = d[i];
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic idle_chk(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_demand"}, ebus_demand, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_data"}, ebus_data, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic xfer(input logic [N-1:0] r, input int ackd, input bit rnd, input bit drop,
                        input bit ackg, input bit abort);
        int w;
        bit ack, tmo, ex;
        logic [N-1:0] ow;
        w  = pick(r, rr);
        ow = N'(1) << w;
        req = r;
        drive_data(rnd);
        tick;
        chk("g1_grant", grant, ow);
        chk("g1_busy", busy, 1);
        chk("g1_demand", ebus_demand, 0);
        chk("g1_data", ebus_data, d[w]);
        for (int s = 1; s < S; s++) begin
            if (drop) req = '0;
            xfer_ack = ackg;
            drive_data(rnd);
            tick;
            chk("g_grant", grant, ow);
            chk("g_demand", ebus_demand, 0);
            chk("g_data", ebus_data, d[w]);
            chk("g_done", done, 0);
        end
        if (drop) req = '0;
        xfer_ack = ackg;
        drive_data(rnd);
        tick;
        chk("d1_demand", ebus_demand, 1);
        chk("d1_grant", grant, ow);
        chk("d1_data", ebus_data, d[w]);
        chk("d1_done", done, 0);
        if (abort) begin
            xfer_ack = 1'b0;
            crobar = 1'b1;
            tick;
            crobar = 1'b0;
            idle_chk("abort");
            rr = 0;
            return;
        end
        ex = 1'b0;
        for (int c = 1; c <= 300 && !ex; c++) begin
            ack = (c == ackd + 1);
            xfer_ack = ack;
            drive_data(rnd);
            tick;
`ifdef EBUS_ARB_TIMEOUT_EN
            tmo = !ack && c == T;
`else
            tmo = 1'b0;
`endif
            ex = ack || tmo;
            if (ex) begin
                chk("r_done", done, 1);
                chk("r_tmo", timeout_err, tmo);
                chk("r_grant", grant, 0);
                chk("r_demand", ebus_demand, 0);
                chk("r_data", ebus_data, 0);
                chk("r_busy", busy, 1);
            end else begin
                chk("d_demand", ebus_demand, 1);
                chk("d_done", done, 0);
                chk("d_grant", grant, ow);
                chk("d_data", ebus_data, d[w]);
            end
        end
        chk("demand_bound", ex, 1);
        xfer_ack = 1'b0;
        tick;
        chk("i_busy", busy, 0);
        chk("i_done", done, 0);
        chk("i_tmo", timeout_err, 0);
        chk("i_grant", grant, 0);
        rr = (w + 1) % N;
    endtask

    initial begin
        crobar   = 1'b1;
        req      = '1;
        xfer_ack = 1'b0;
        drive_data(1);
        repeat (3) tick;
        idle_chk("reset");
        crobar = 1'b0;
        req    = '0;
        repeat (2) tick;
        idle_chk("noreq");
        rr = 0;

        drive_data(1);
        d[3] = 36'o123456701234;
        drive_data(0);
        xfer(8'h08, 1, 0, 0, 0, 0);

        repeat (4) xfer(8'h05, $urandom_range(0, 2), 1, 0, 0, 0);

        crobar = 1'b1;
        tick;
        crobar = 1'b0;
        rr = 0;
        xfer(8'h81, 0, 1, 0, 0, 0);
        xfer(8'h81, 1, 1, 0, 0, 0);

        xfer(8'h12, 0, 1, 0, 0, 1);
        xfer(8'h20, 0, 1, 0, 0, 0);

        xfer(8'hC0, 2, 1, 1, 1, 0);
        xfer(8'h03, 0, 1, 0, 1, 0);

`ifdef EBUS_ARB_TIMEOUT_EN
        xfer(8'h02, 99, 1, 0, 0, 0);
        xfer(8'h02, T - 1, 1, 0, 0, 0);
`endif

        req = '0;
        repeat (20) xfer(N'($urandom_range(1, 255)), $urandom_range(0, 2), 1,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

        req = '0;
        tick;
        idle_chk("final");

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
